// File: rtl/instr_sequencer.sv
// ============================================================================
// Module   : instr_sequencer
// Brief    : Program store + PC + FSM that feeds a processor's DIN/run/done
//            interface. Optional watchdog enabled by macro SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
  parameter int DATA_W  = 9,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              done,
  output logic              run,
  output logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [7:0]        instr_count,
  output logic              error
);

  localparam int         DEPTH   = 2 ** ADDR_W;
  localparam logic [2:0] OP_MVI  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_IMM   = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  generate
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("instr_sequencer: TIMEOUT must be at least 1");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   w_word;
  logic [2:0]          w_op;
  logic                w_timeout_hit;

  assign busy = (state_q == S_FETCH) || (state_q == S_IMM) || (state_q == S_EXEC);

  // Store is write-blocked while a program is running; contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && load_we && !busy) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign w_word = mem_q[pc_q];
  assign w_op   = w_word[DATA_W-1 -: 3];

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            w_restart;

  assign w_restart     = start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign w_timeout_hit = (state_q == S_EXEC) && !done && (wd_q == WD_W'(TIMEOUT - 1));

  // Counter sits at zero outside EXEC, so it is clear on every entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q != S_EXEC) begin
        wd_q <= '0;
      end else if (!done) begin
        wd_q <= wd_q + 1'b1;
      end
      if (w_restart) begin
        err_q <= 1'b0;
      end else if (w_timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign error = err_q;
`else
  assign w_timeout_hit = 1'b0;
  assign error         = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    run     = 1'b0;
    din     = '0;
    halted  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        din = w_word;
        // The sentinel is shown on din but never handed over with run.
        if (w_op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          run     = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = (w_op == OP_MVI) ? S_IMM : S_EXEC;
        end
      end
      S_IMM: begin
        din     = w_word;
        run     = 1'b1;
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        run = 1'b1;
        if (done) begin
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d = S_FETCH;
        end else if (w_timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc          = pc_q;
  assign instr_count = cnt_q;

endmodule

`default_nettype wire
